rgb_led_arbiter: RTL and testbench
==================================

RGB_LED_ARBITER -- requirements
Module: rgb_led_arbiter

Interface
REQ-001 SHALL have parameter HOLD_TICKS, default 10, minimum cycles an owner keeps the LED before it can be preempted (legal range >= 1).
REQ-002 SHALL have parameter BLINK_TICKS, default 4, blink half-period in cycles (used only when RGB_ARB_BLINK_EN is defined).
REQ-003 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req  input  3  per-requester LED request; bit i = requester i.
REQ-006 SHALL have ports color0, color1, color2  input  3 each  active-low color of requester i (bit2=R, bit1=G, bit0=B; 3'b011=red, 3'b101=green, 3'b110=blue).
REQ-007 SHALL have port grant  output  3  one-hot current owner; 3'b000 = no owner.
REQ-008 SHALL have port out  output  3  active-low LED drive; 3'b111 = off.
REQ-009 SHALL have port busy  output  1  high exactly when grant != 3'b000.

Function
REQ-010 SHALL implement states IDLE, OWN, GAP; all outputs registered.
REQ-011 IDLE: grant=000, out=111; at an edge with req!=000 SHALL pick a winner, move to OWN, and set grant and out in the same edge (1-cycle latency from req sampled).
REQ-012 Winner selection SHALL be round-robin: search indices ptr+1, ptr+2, ptr (mod 3); ptr SHALL update to the winner on each grant.
REQ-013 OWN: out SHALL equal the owner's color as sampled at each edge; color changes by the owner appear on out one cycle later.
REQ-014 OWN: hold counter SHALL clear to 0 on entry, increment each cycle, and saturate at HOLD_TICKS-1 (width $clog2(HOLD_TICKS+1)).
REQ-015 OWN: if the owner's req is low at an edge, SHALL move to GAP regardless of counter.
REQ-016 OWN: if counter == HOLD_TICKS-1 and any other req bit is high, SHALL move to GAP.
REQ-017 OWN: a sole requester SHALL keep ownership indefinitely; counter stays saturated.
REQ-018 GAP: exactly one cycle with grant=000, out=111; at its edge, SHALL arbitrate as in IDLE (to OWN if req!=000, else IDLE).
REQ-019 Simultaneous owner-drop and other-request SHALL take the REQ-015 path (one GAP cycle, then round-robin).
REQ-020 Unreachable state encodings SHALL recover to IDLE at the next edge with outputs off.

Reset
REQ-021 rst high SHALL immediately, without a clock edge, force state=IDLE, grant=000, out=111, busy=0, counter=0, ptr=2 (requester 0 wins first).
REQ-022 Reset asserted mid-OWN SHALL drop ownership; after release the arbitration restarts from REQ-021 values.

Configuration
REQ-023 Macro RGB_ARB_BLINK_EN: when defined, during OWN, out SHALL alternate owner color / 111 every BLINK_TICKS cycles, starting with color on OWN entry; blink counter cleared on entry and reset.
REQ-024 Without RGB_ARB_BLINK_EN, out SHALL show the owner color solidly in OWN and no blink logic SHALL be synthesized; grant/busy behaviour is identical in both builds.

Verification (HOLD_TICKS=4, BLINK_TICKS=4)
REQ-025 Reset: rst=1 with req=111 -> out=111, grant=000, busy=0, asynchronously, before any clock edge.
REQ-026 Sole owner: req=001, color0=011 -> after 1 edge grant=001, out=011, busy=1; held unchanged for 20 cycles.
REQ-027 Preemption: req0 owning, req1 rises in ownership cycle 1 -> grant=001 for 4 cycles total, 1 GAP cycle (out=111, grant=000), then grant=010, out=color1.
REQ-028 Round-robin: req=111 constant from reset -> grant sequence 001(4),000(1),010(4),000(1),100(4),000(1),001.
REQ-029 Early release: owner 0 drops req at counter=1 with req2 high -> GAP next cycle, then grant=100; async rst mid-OWN -> out=111 immediately, then req=111 yields grant=001.
REQ-030 Blink build: sole owner color0=101 -> out 101 x4, 111 x4, 101 x4; non-blink build -> out 101 constant.

Source files
------------

// File: rtl/rgb_led_arbiter.sv
// Round-robin arbiter that gives one of three requesters ownership of a shared active-low RGB LED.
// Optional macro RGB_ARB_BLINK_EN makes the owner's colour blink with a BLINK_TICKS half-period.
module rgb_led_arbiter #(
    parameter int unsigned HOLD_TICKS  = 10,
    parameter int unsigned BLINK_TICKS = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] req,
    input  logic [2:0] color0,
    input  logic [2:0] color1,
    input  logic [2:0] color2,
    output logic [2:0] grant,
    output logic [2:0] out,
    output logic       busy
);

    localparam int unsigned      CNT_W    = $clog2(HOLD_TICKS + 1);
    localparam logic [CNT_W-1:0] HOLD_MAX = CNT_W'(HOLD_TICKS - 1);

    if (HOLD_TICKS < 1 || BLINK_TICKS < 1) begin : g_param_check
        $error("rgb_led_arbiter: HOLD_TICKS and BLINK_TICKS must be >= 1");
    end

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN  = 2'b01,
        GAP  = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [2:0]         grant_q, grant_d;
    logic [2:0]         out_q, out_d;
    logic               busy_q, busy_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [1:0]         ptr_q, ptr_d;

`ifdef RGB_ARB_BLINK_EN
    localparam int unsigned      BLK_W   = $clog2(BLINK_TICKS + 1);
    localparam logic [BLK_W-1:0] BLK_MAX = BLK_W'(BLINK_TICKS - 1);

    logic [BLK_W-1:0]   bcnt_q, bcnt_d;
    logic               phase_q, phase_d;
`endif

    logic [1:0] first_idx;
    logic [1:0] cand;
    logic [1:0] win_idx;
    logic       win_vld;
    logic [2:0] win_color;
    logic [2:0] own_color;
    logic       owner_req;
    logic       other_req;

    // Search order starts just after the last winner; ptr doubles as the owner index in OWN.
    always_comb begin
        case (ptr_q)
            2'd0:    first_idx = 2'd1;
            2'd1:    first_idx = 2'd2;
            default: first_idx = 2'd0;
        endcase
        cand    = 2'd0;
        win_idx = 2'd0;
        win_vld = 1'b0;
        for (int unsigned k = 0; k < 3; k++) begin
            cand = 2'((32'(first_idx) + k) % 32'd3);
            if (!win_vld && req[cand]) begin
                win_idx = cand;
                win_vld = 1'b1;
            end
        end
    end

    always_comb begin
        case (win_idx)
            2'd0:    win_color = color0;
            2'd1:    win_color = color1;
            default: win_color = color2;
        endcase
        case (ptr_q)
            2'd0:    own_color = color0;
            2'd1:    own_color = color1;
            default: own_color = color2;
        endcase
        owner_req = |(req & grant_q);
        other_req = |(req & ~grant_q);
    end

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        out_d   = out_q;
        busy_d  = busy_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
`ifdef RGB_ARB_BLINK_EN
        bcnt_d  = bcnt_q;
        phase_d = phase_q;
`endif
        case (state_q)
            IDLE, GAP: begin
                cnt_d = '0;
                if (win_vld) begin
                    state_d = OWN;
                    grant_d = 3'b001 << win_idx;
                    out_d   = win_color;
                    busy_d  = 1'b1;
                    ptr_d   = win_idx;
`ifdef RGB_ARB_BLINK_EN
                    bcnt_d  = '0;
                    phase_d = 1'b0;
`endif
                end else begin
                    state_d = IDLE;
                    grant_d = '0;
                    out_d   = '1;
                    busy_d  = 1'b0;
                end
            end
            OWN: begin
                // Owner drop is tested first so a simultaneous drop and new request still costs one GAP.
                if (!owner_req || (cnt_q == HOLD_MAX && other_req)) begin
                    state_d = GAP;
                    grant_d = '0;
                    out_d   = '1;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                end else begin
                    if (cnt_q != HOLD_MAX) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
`ifdef RGB_ARB_BLINK_EN
                    if (bcnt_q == BLK_MAX) begin
                        bcnt_d  = '0;
                        phase_d = ~phase_q;
                    end else begin
                        bcnt_d  = bcnt_q + BLK_W'(1);
                    end
                    out_d = phase_d ? 3'b111 : own_color;
`else
                    out_d = own_color;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
                out_d   = '1;
                busy_d  = 1'b0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            grant_q <= '0;
            out_q   <= '1;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
            ptr_q   <= 2'd2;
`ifdef RGB_ARB_BLINK_EN
            bcnt_q  <= '0;
            phase_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            out_q   <= out_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
`ifdef RGB_ARB_BLINK_EN
            bcnt_q  <= bcnt_d;
            phase_q <= phase_d;
`endif
        end
    end

    assign grant = grant_q;
    assign out   = out_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_rgb_led_arbiter.sv
// Directed bench for rgb_led_arbiter with HOLD_TICKS=4, BLINK_TICKS=4.
// Blink expectations follow the RGB_ARB_BLINK_EN macro of the build.
module tb_rgb_led_arbiter;

    localparam int unsigned HT = 4;
    localparam int unsigned BT = 4;
    localparam logic [2:0]  R  = 3'b011;
    localparam logic [2:0]  G  = 3'b101;
    localparam logic [2:0]  B  = 3'b110;
    localparam int          NV = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [2:0] req = 3'b000;
    logic [2:0] color0 = R;
    logic [2:0] color1 = G;
    logic [2:0] color2 = B;
    logic [2:0] grant;
    logic [2:0] out;
    logic       busy;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    rgb_led_arbiter #(
        .HOLD_TICKS (HT),
        .BLINK_TICKS(BT)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .color0(color0),
        .color1(color1),
        .color2(color2),
        .grant (grant),
        .out   (out),
        .busy  (busy)
    );

    typedef struct packed {
        logic       rst;
        logic [2:0] req;
        logic [2:0] c0;
        logic [2:0] c1;
        logic [2:0] c2;
        logic [2:0] eg;
        logic [2:0] eo;
        logic       eb;
    } vec_t;

    vec_t vecs [NV];

    function automatic vec_t mk(input logic r, input logic [2:0] rq, input logic [2:0] a,
                                input logic [2:0] b, input logic [2:0] c, input logic [2:0] eg,
                                input logic [2:0] eo, input logic eb);
        vec_t v;
        v.rst = r; v.req = rq; v.c0 = a; v.c1 = b; v.c2 = c;
        v.eg = eg; v.eo = eo; v.eb = eb;
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string nm, input logic [2:0] eg, input logic [2:0] eo, input logic eb);
        checks++;
        if (grant !== eg || out !== eo || busy !== eb) begin
            errors++;
            $display("FAIL %s: got grant=%b out=%b busy=%b, expected grant=%b out=%b busy=%b",
                     nm, grant, out, busy, eg, eo, eb);
        end
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        // Round-robin with all requesting from reset
        vecs[0]  = mk(1'b1, 3'b111, R, G, B, 3'b000, 3'b111, 1'b0);
        for (int i = 1; i <= 4; i++)  vecs[i] = mk(1'b0, 3'b111, R, G, B, 3'b001, R, 1'b1);
        vecs[5]  = mk(1'b0, 3'b111, R, G, B, 3'b000, 3'b111, 1'b0);
        for (int i = 6; i <= 9; i++)  vecs[i] = mk(1'b0, 3'b111, R, G, B, 3'b010, G, 1'b1);
        vecs[10] = mk(1'b0, 3'b111, R, G, B, 3'b000, 3'b111, 1'b0);
        for (int i = 11; i <= 14; i++) vecs[i] = mk(1'b0, 3'b111, R, G, B, 3'b100, B, 1'b1);
        vecs[15] = mk(1'b0, 3'b111, R, G, B, 3'b000, 3'b111, 1'b0);
        vecs[16] = mk(1'b0, 3'b111, R, G, B, 3'b001, R, 1'b1);
        // Preemption: req1 rises in first ownership cycle
        vecs[17] = mk(1'b1, 3'b000, R, G, B, 3'b000, 3'b111, 1'b0);
        vecs[18] = mk(1'b0, 3'b001, R, G, B, 3'b001, R, 1'b1);
        for (int i = 19; i <= 21; i++) vecs[i] = mk(1'b0, 3'b011, R, G, B, 3'b001, R, 1'b1);
        vecs[22] = mk(1'b0, 3'b011, R, G, B, 3'b000, 3'b111, 1'b0);
        vecs[23] = mk(1'b0, 3'b011, R, G, B, 3'b010, G, 1'b1);
        // Owner colour changes track one edge later
        vecs[24] = mk(1'b0, 3'b010, R, B, B, 3'b010, B, 1'b1);
        vecs[25] = mk(1'b0, 3'b010, R, R, B, 3'b010, R, 1'b1);
        vecs[26] = mk(1'b0, 3'b000, R, G, B, 3'b000, 3'b111, 1'b0);
        vecs[27] = mk(1'b0, 3'b000, R, G, B, 3'b000, 3'b111, 1'b0);
        vecs[28] = mk(1'b0, 3'b100, R, G, B, 3'b100, B, 1'b1);
        vecs[29] = mk(1'b0, 3'b101, R, G, B, 3'b100, B, 1'b1);

        #1 rst = 1'b1; req = 3'b111;
        #1 check("async_reset_pre_edge", 3'b000, 3'b111, 1'b0);

        for (int i = 0; i < NV; i++) begin
            rst = vecs[i].rst; req = vecs[i].req;
            color0 = vecs[i].c0; color1 = vecs[i].c1; color2 = vecs[i].c2;
            tick();
            check($sformatf("vec%0d", i), vecs[i].eg, vecs[i].eo, vecs[i].eb);
        end

        // Sole owner keeps the LED with a saturated hold counter
        color0 = R; color1 = G; color2 = B;
        rst = 1'b1; req = 3'b000; tick();
        rst = 1'b0; req = 3'b001; tick();
        check("sole_grant", 3'b001, R, 1'b1);
        for (int i = 0; i < 20; i++) begin
            tick();
            check($sformatf("sole_hold%0d", i), 3'b001, R, 1'b1);
        end

        // Early release at counter=1 with req2 waiting
        rst = 1'b1; req = 3'b000; tick();
        rst = 1'b0; req = 3'b101; tick();
        check("early_own_c0", 3'b001, R, 1'b1);
        tick();
        check("early_own_c1", 3'b001, R, 1'b1);
        req = 3'b100; tick();
        check("early_gap", 3'b000, 3'b111, 1'b0);
        tick();
        check("early_grant2", 3'b100, B, 1'b1);

        // Asynchronous reset mid-ownership
        #2 rst = 1'b1;
        #1 check("mid_own_async_reset", 3'b000, 3'b111, 1'b0);
        req = 3'b111; tick();
        check("reset_held", 3'b000, 3'b111, 1'b0);
        rst = 1'b0; tick();
        check("restart_grant0", 3'b001, R, 1'b1);

        // Blink pattern (or solid colour without the macro)
        rst = 1'b1; req = 3'b000; color0 = G; tick();
        rst = 1'b0; req = 3'b001;
        for (int i = 0; i < 12; i++) begin
            logic [2:0] eo;
`ifdef RGB_ARB_BLINK_EN
            eo = (((i / 4) % 2) == 1) ? 3'b111 : G;
`else
            eo = G;
`endif
            tick();
            check($sformatf("blink%0d", i), 3'b001, eo, 1'b1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
